// File: rtl/acc_alu_cache_datapath.sv
// BeeF byte datapath: accumulator, 8-bit ALU, loop-return PC cache
// and bracket-depth byte.
module acc_alu_cache_datapath #(
  parameter int DATA_W = 8,
  parameter int PC_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              acc_write,
  input  logic              acc_src,
  input  logic [2:0]        alu_op,
  input  logic [1:0]        alu_src,
  input  logic [DATA_W-1:0] stack_out,
  input  logic [DATA_W-1:0] head_out,
  input  logic [DATA_W-1:0] mem_out,
  input  logic              cache_write,
  input  logic [1:0]        loader_select,
  input  logic [PC_W-1:0]   pc,
  output logic [DATA_W-1:0] acc_out,
  output logic              acc_zero,
  output logic [DATA_W-1:0] alu_out,
  output logic [DATA_W-1:0] cache_out,
  output logic [DATA_W-1:0] save_out,
  output logic [PC_W-1:0]   load_out
);

  localparam int HI_W = PC_W - 8;

  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] depth;
  logic [PC_W-1:0]   pc_cache;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] hi_byte;

  always_comb begin
    unique case (alu_src)
      2'b00:   alu_a = acc;
      2'b01:   alu_a = stack_out;
      2'b10:   alu_a = head_out;
      default: alu_a = depth;
    endcase
  end

  always_comb begin
    case (alu_op)
      3'b001:  alu_out = alu_a + DATA_W'(1);
      3'b010:  alu_out = alu_a - DATA_W'(1);
      3'b011:  alu_out = '0;
      3'b100:  alu_out = mem_out;
      default: alu_out = alu_a;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc <= '0;
    end else if (acc_write) begin
      acc <= acc_src ? mem_out : alu_out;
    end
  end

  // Each select touches only its own field of the cache.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_cache <= '0;
      depth    <= '0;
    end else if (cache_write) begin
      unique case (loader_select)
        2'b00: pc_cache <= pc;
        2'b01: pc_cache[7:0] <= mem_out;
        2'b10: pc_cache[PC_W-1:8] <= mem_out[HI_W-1:0];
        2'b11: depth <= alu_out;
      endcase
    end
  end

  always_comb begin
    hi_byte = '0;
    hi_byte[HI_W-1:0] = pc_cache[PC_W-1:8];
  end

  assign save_out  = (loader_select == 2'b10) ? hi_byte
                                              : pc_cache[7:0];
  assign acc_out   = acc;
  assign acc_zero  = (acc == '0);
  assign cache_out = depth;
  assign load_out  = pc_cache;

endmodule

// File: tb/tb_acc_alu_cache_datapath.sv
// Directed and random checks of the BeeF byte datapath
// against a plain-arithmetic reference model.
module tb_acc_alu_cache_datapath;

  logic        clk;
  logic        reset;
  logic        acc_write;
  logic        acc_src;
  logic [2:0]  alu_op;
  logic [1:0]  alu_src;
  logic [7:0]  stack_out;
  logic [7:0]  head_out;
  logic [7:0]  mem_out;
  logic        cache_write;
  logic [1:0]  loader_select;
  logic [15:0] pc;
  logic [7:0]  acc_out;
  logic        acc_zero;
  logic [7:0]  alu_out;
  logic [7:0]  cache_out;
  logic [7:0]  save_out;
  logic [15:0] load_out;

  int errors;
  int checks;
  int m_acc;
  int m_pc;
  int m_depth;

  acc_alu_cache_datapath #(.DATA_W(8), .PC_W(16)) dut (
    .clk(clk),
    .reset(reset),
    .acc_write(acc_write),
    .acc_src(acc_src),
    .alu_op(alu_op),
    .alu_src(alu_src),
    .stack_out(stack_out),
    .head_out(head_out),
    .mem_out(mem_out),
    .cache_write(cache_write),
    .loader_select(loader_select),
    .pc(pc),
    .acc_out(acc_out),
    .acc_zero(acc_zero),
    .alu_out(alu_out),
    .cache_out(cache_out),
    .save_out(save_out),
    .load_out(load_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int ref_alu();
    int a;
    case (alu_src)
      2'd0:    a = m_acc;
      2'd1:    a = int'(stack_out);
      2'd2:    a = int'(head_out);
      default: a = m_depth;
    endcase
    case (alu_op)
      3'd1:    return (a + 1) % 256;
      3'd2:    return (a + 255) % 256;
      3'd3:    return 0;
      3'd4:    return int'(mem_out);
      default: return a;
    endcase
  endfunction

  function automatic int ref_save();
    if (loader_select == 2'd2) return m_pc / 256;
    return m_pc % 256;
  endfunction

  task automatic check_regs(input string tag);
    check({tag, ".acc"}, 32'(acc_out), 32'(m_acc));
    check({tag, ".zero"}, 32'(acc_zero), 32'(m_acc == 0));
    check({tag, ".depth"}, 32'(cache_out), 32'(m_depth));
    check({tag, ".load"}, 32'(load_out), 32'(m_pc));
  endtask

  // Predict the post-edge state from pre-edge values, clock, compare.
  task automatic step(input string tag);
    int a;
    int n_acc;
    int n_pc;
    int n_depth;
    a = ref_alu();
    n_acc = m_acc;
    n_pc = m_pc;
    n_depth = m_depth;
    if (acc_write) n_acc = acc_src ? int'(mem_out) : a;
    if (cache_write) begin
      case (loader_select)
        2'd0: n_pc = int'(pc);
        2'd1: n_pc = (m_pc / 256) * 256 + int'(mem_out);
        2'd2: n_pc = int'(mem_out) * 256 + m_pc % 256;
        default: n_depth = a;
      endcase
    end
    @(posedge clk);
    #1;
    m_acc = n_acc;
    m_pc = n_pc;
    m_depth = n_depth;
    check_regs(tag);
  endtask

  task automatic idle();
    acc_write = 0;
    cache_write = 0;
    acc_src = 0;
    alu_op = 3'd0;
    alu_src = 2'd0;
    loader_select = 2'd0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    reset = 0;
    #1;
    m_acc = 0;
    m_pc = 0;
    m_depth = 0;
    check_regs("reset");
    @(negedge clk);
    reset = 1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    m_acc = 0;
    m_pc = 0;
    m_depth = 0;
    reset = 0;
    idle();
    stack_out = 8'h00;
    head_out = 8'h00;
    mem_out = 8'h00;
    pc = 16'h0000;
    #3;
    check_regs("por");
    @(negedge clk);
    reset = 1;

    acc_src = 1; mem_out = 8'hFF; acc_write = 1;
    step("ld_ff");
    acc_src = 0; alu_src = 2'd0; alu_op = 3'd1;
    #1 check("inc_wrap.alu", 32'(alu_out), 32'h00);
    step("inc_wrap");

    idle();
    alu_src = 2'd1; stack_out = 8'h80; alu_op = 3'd2;
    #1 check("dec.alu", 32'(alu_out), 32'h7F);
    alu_op = 3'd3;
    #1 check("zero.alu", 32'(alu_out), 32'h00);
    alu_op = 3'd4; mem_out = 8'h5C;
    #1 check("mem.alu", 32'(alu_out), 32'h5C);
    alu_op = 3'd6; alu_src = 2'd2; head_out = 8'hA7;
    #1 check("pass6.alu", 32'(alu_out), 32'hA7);
    alu_op = 3'd2; alu_src = 2'd0;
    #1 check("dec_wrap.alu", 32'(alu_out), 32'hFF);

    idle();
    pc = 16'h1234; loader_select = 2'd0; cache_write = 1;
    step("ld_pc");
    check("ld_pc.val", 32'(load_out), 32'h1234);
    cache_write = 0;
    loader_select = 2'd1;
    #1 check("save_lo", 32'(save_out), 32'h34);
    loader_select = 2'd2;
    #1 check("save_hi", 32'(save_out), 32'h12);

    cache_write = 1; loader_select = 2'd1; mem_out = 8'hCD;
    step("ld_lo");
    loader_select = 2'd2; mem_out = 8'hAB;
    step("ld_hi");
    check("ld_hilo.val", 32'(load_out), 32'hABCD);

    idle();
    do_reset();
    pc = 16'h5A5A; cache_write = 1; loader_select = 2'd0;
    step("pc_5a");
    loader_select = 2'd3; alu_src = 2'd3; alu_op = 3'd1;
    step("depth1");
    step("depth2");
    check("depth2.val", 32'(cache_out), 32'h02);
    check("depth2.pc", 32'(load_out), 32'h5A5A);

    idle();
    acc_write = 1; acc_src = 1; mem_out = 8'h41;
    step("ld_41");
    acc_src = 0; alu_src = 2'd0; alu_op = 3'd1;
    cache_write = 1; loader_select = 2'd3;
    step("simul");
    check("simul.acc", 32'(acc_out), 32'h42);
    check("simul.depth", 32'(cache_out), 32'h42);

    idle();
    acc_write = 1; acc_src = 1; mem_out = 8'h37;
    step("ld_37");
    idle();
    do_reset();

    for (int i = 0; i < 400; i++) begin
      acc_write = 1'($urandom);
      acc_src = 1'($urandom);
      alu_op = 3'($urandom);
      alu_src = 2'($urandom);
      stack_out = 8'($urandom);
      head_out = 8'($urandom);
      mem_out = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      cache_write = 1'($urandom);
      loader_select = 2'($urandom);
      pc = 16'($urandom);
      #1;
      check("rnd.alu", 32'(alu_out), 32'(ref_alu()));
      check("rnd.save", 32'(save_out), 32'(ref_save()));
      step("rnd");
      if (i == 200) begin
        idle();
        do_reset();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
